// File: rtl/core_bus.sv
`default_nettype none
// ============================================================================
// core_bus : core-CPU bus responder; req/ack memory bridge plus local I/O page
// Revision : 1.0
// ============================================================================
module core_bus #(
  parameter logic [7:0]  IO_PAGE = 8'hBF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] core_address,
  input  logic [7:0]  core_out,
  input  logic        core_we,
  input  logic        core_rd,
  output logic [7:0]  core_in,
  output logic        core_ce,
  input  logic        halt,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  localparam logic [1:0] c_st_issue  = 2'd0;
  localparam logic [1:0] c_st_wait   = 2'd1;
  localparam logic [1:0] c_st_step   = 2'd2;
  localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  core_in_q, core_in_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_address_q, mem_address_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        bus_err_q, bus_err_d;
  logic [15:0] cycnt_q, cycnt_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        cyc_hold_q, cyc_hold_d;
  logic        is_io;
  logic        wait_done;
  logic [7:0]  io_rdata;
  logic        unused_rd;

  // Every non-write is a read, so the read hint carries no information.
  assign unused_rd = core_rd;
  assign is_io     = (core_address[15:8] == IO_PAGE);
  assign wait_done = (wait_cnt_q == c_wait_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= c_st_issue;
      core_in_q     <= 8'h00;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= 16'h0000;
      mem_wdata_q   <= 8'h00;
      bus_err_q     <= 1'b0;
      cycnt_q       <= 16'h0000;
      shadow_q      <= 8'h00;
      wait_cnt_q    <= 8'h00;
      cyc_hold_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      core_in_q     <= core_in_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      bus_err_q     <= bus_err_d;
      cycnt_q       <= cycnt_d;
      shadow_q      <= shadow_d;
      wait_cnt_q    <= wait_cnt_d;
      cyc_hold_q    <= cyc_hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      c_st_issue: if (!halt) state_d = is_io ? c_st_step : c_st_wait;
      c_st_wait:  if (mem_ack || wait_done) state_d = c_st_step;
      c_st_step:  state_d = c_st_issue;
      default:    state_d = c_st_issue;
    endcase
  end

  always_comb begin
    case (core_address[7:0])
      8'h00:   io_rdata = cycnt_q[7:0];
      8'h01:   io_rdata = shadow_q;
      8'h02:   io_rdata = {7'b0, bus_err_q};
      default: io_rdata = 8'hFF;
    endcase
  end

  always_comb begin
    core_in_d     = core_in_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    bus_err_d     = bus_err_q;
    cycnt_d       = cycnt_q;
    shadow_d      = shadow_q;
    wait_cnt_d    = wait_cnt_q;
    cyc_hold_d    = 1'b0;
    case (state_q)
      c_st_issue: begin
        if (!halt && is_io) begin
          if (core_we) begin
            if (core_address[7:0] == 8'h00) begin
              cycnt_d    = 16'h0000;
              cyc_hold_d = 1'b1;
            end else if (core_address[7:0] == 8'h02 && core_out[0]) begin
              bus_err_d = 1'b0;
            end
          end else begin
            core_in_d = io_rdata;
            if (core_address[7:0] == 8'h00) shadow_d = cycnt_q[15:8];
          end
        end else if (!halt) begin
          mem_address_d = core_address;
          mem_wdata_d   = core_out;
          mem_we_d      = core_we;
          mem_req_d     = 1'b1;
          wait_cnt_d    = 8'h00;
        end
      end
      c_st_wait: begin
        // An ack on the final allowed clock still completes the access normally.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) core_in_d = mem_rdata;
        end else if (wait_done) begin
          mem_req_d = 1'b0;
          core_in_d = 8'hFF;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      c_st_step: begin
        if (!cyc_hold_q) cycnt_d = cycnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    core_ce     = (state_q == c_st_step);
    core_in     = core_in_q;
    mem_req     = mem_req_q;
    mem_we      = mem_we_q;
    mem_address = mem_address_q;
    mem_wdata   = mem_wdata_q;
    bus_err     = bus_err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_core_bus.sv
`default_nettype none
// ============================================================================
// tb_core_bus : self-checking bench for core_bus with a bus-cycle level model
// Revision    : 1.0
// ============================================================================
module tb_core_bus;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] core_address;
  logic [7:0]  core_out;
  logic        core_we;
  logic        core_rd;
  logic [7:0]  core_in;
  logic        core_ce;
  logic        halt;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  core_bus #(.IO_PAGE(8'hBF), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .core_address(core_address), .core_out(core_out), .core_we(core_we),
    .core_rd(core_rd), .core_in(core_in), .core_ce(core_ce), .halt(halt),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_req(mem_req), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state at bus-cycle granularity.
  logic [15:0] m_cnt;
  logic [7:0]  m_shadow;
  logic [7:0]  m_core_in;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset;
    m_cnt = 16'h0; m_shadow = 8'h0; m_core_in = 8'h0; m_err = 1'b0;
  endtask

  // One full core bus cycle, starting in an ISSUE clock; k<0 means no ack.
  task automatic bus_cycle(input logic [15:0] addr, input logic we, input logic [7:0] wdata,
                           input logic [7:0] rdata, input int k, input bit stray,
                           input bit halt_in_wait);
    bit io, tmo, done, req_bad, fields_bad;
    int exp_lat, exp_req, lat, req_clk;
    logic [7:0] exp_in;
    bit clr;
    io = (addr[15:8] == 8'hBF);
    tmo = !io && (k < 0 || k >= TO);
    clr = 1'b0;
    exp_in = m_core_in;
    if (io) begin
      exp_lat = 2; exp_req = 0;
      if (we) begin
        if (addr[7:0] == 8'h00) clr = 1'b1;
        if (addr[7:0] == 8'h02 && wdata[0]) m_err = 1'b0;
      end else begin
        case (addr[7:0])
          8'h00: begin exp_in = m_cnt[7:0]; m_shadow = m_cnt[15:8]; end
          8'h01: exp_in = m_shadow;
          8'h02: exp_in = {7'b0, m_err};
          default: exp_in = 8'hFF;
        endcase
      end
    end else if (tmo) begin
      exp_lat = TO + 2; exp_req = TO; exp_in = 8'hFF; m_err = 1'b1;
    end else begin
      exp_lat = 3 + k; exp_req = k + 1;
      if (!we) exp_in = rdata;
    end
    m_core_in = exp_in;
    m_cnt = clr ? 16'h0 : m_cnt + 16'd1;

    core_address = addr; core_we = we; core_rd = !we; core_out = wdata;
    done = 0; req_bad = 0; fields_bad = 0; lat = 0; req_clk = 0;
    for (int c = 1; c <= 400 && !done; c++) begin
      if (c == 1 && stray) begin mem_ack = 1'b1; mem_rdata = 8'h33; end
      if (mem_req) begin
        req_clk++;
        if (io) req_bad = 1;
        if (mem_address !== addr || mem_we !== we || mem_wdata !== wdata) fields_bad = 1;
        if (halt_in_wait) halt = 1'b1;
        if (!tmo && req_clk == k + 1) begin mem_ack = 1'b1; mem_rdata = rdata; end
      end
      if (core_ce) begin
        done = 1; lat = c;
      end else begin
        tick;
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
      end
    end
    check("cycle_done", done, 1);
    check("latency", lat, exp_lat);
    check("core_in", core_in, exp_in);
    check("req_clocks", req_clk, exp_req);
    check("io_no_req", req_bad, 0);
    check("req_fields", fields_bad, 0);
    check("bus_err", bus_err, m_err);
    if (done) begin
      tick;
      check("ce_pulse", core_ce, 0);
    end
  endtask

  initial begin
    reset_n = 1'b0; core_address = 16'h0; core_out = 8'h0; core_we = 1'b0; core_rd = 1'b1;
    halt = 1'b0; mem_rdata = 8'h0; mem_ack = 1'b0;
    model_reset();
    #1;
    check("rst_ce", core_ce, 0);
    check("rst_core_in", core_in, 8'h00);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_address, 16'h0);
    check("rst_wdata", mem_wdata, 8'h0);
    check("rst_err", bus_err, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Zero-wait reads, then a 4-wait write.
    bus_cycle(16'h0000, 1'b0, 8'h00, 8'hA9, 0, 0, 0);
    bus_cycle(16'h0001, 1'b0, 8'h00, 8'h17, 0, 0, 0);
    bus_cycle(16'h0200, 1'b1, 8'h5C, 8'h00, 4, 0, 0);

    // Timeout, then a late ack landing in the next ISSUE clock.
    bus_cycle(16'h1000, 1'b0, 8'h00, 8'h00, -1, 0, 0);
    bus_cycle(16'h3000, 1'b0, 8'h00, 8'h6E, 2, 1, 0);
    bus_cycle(16'hBF02, 1'b0, 8'h00, 8'h00, 0, 0, 0);
    bus_cycle(16'hBF02, 1'b1, 8'h01, 8'h00, 0, 0, 0);
    bus_cycle(16'hBF02, 1'b0, 8'h00, 8'h00, 0, 0, 0);

    // Unmapped I/O offsets.
    bus_cycle(16'hBF07, 1'b0, 8'h00, 8'h00, 0, 0, 0);
    bus_cycle(16'hBF07, 1'b1, 8'h99, 8'h00, 0, 0, 0);

    // Halt raised during WAIT: access completes, then the bus idles.
    bus_cycle(16'h0300, 1'b0, 8'h00, 8'h42, 3, 0, 1);
    core_address = 16'h0400; core_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("halt_ce", core_ce, 0);
      check("halt_req", mem_req, 0);
      tick;
    end
    halt = 1'b0;
    bus_cycle(16'h0400, 1'b0, 8'h00, 8'hC3, 1, 0, 0);

    // Reset in the middle of a WAIT.
    core_address = 16'h1234; core_we = 1'b0;
    tick;
    check("pre_rst_req", mem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_req", mem_req, 0);
    check("async_ce", core_ce, 0);
    check("async_addr", mem_address, 16'h0);
    check("async_err", bus_err, 0);
    model_reset();
    core_address = 16'h0000;
    #3;
    reset_n = 1'b1;
    bus_cycle(16'h0000, 1'b0, 8'h00, 8'h5A, 1, 0, 0);

    // Randomized memory traffic up to 300 core cycles since reset.
    for (int n = 0; n < 299; n++) begin
      logic [15:0] a;
      int kk;
      a = 16'($urandom);
      if (a[15:8] == 8'hBF) a[15:8] = 8'h40;
      kk = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 5));
      bus_cycle(a, 1'($urandom), 8'($urandom), 8'($urandom), kk, 1'($urandom), 0);
    end
    bus_cycle(16'hBF00, 1'b0, 8'h00, 8'h00, 0, 0, 0);
    check("cycnt_300", core_in, 8'h2C);
    bus_cycle(16'hBF01, 1'b0, 8'h00, 8'h00, 0, 0, 0);
    check("shadow_300", core_in, 8'h01);

    // Counter clear, then count the cycles since the clear.
    bus_cycle(16'hBF00, 1'b1, 8'h00, 8'h00, 0, 0, 0);
    for (int n = 0; n < 5; n++)
      bus_cycle(16'h0800 + 16'(n), 1'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), 0, 0);
    bus_cycle(16'hBF00, 1'b0, 8'h00, 8'h00, 0, 0, 0);
    check("cycnt_after_clr", core_in, 8'h05);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
